// File: rtl/dmem_ctrl.sv
// Data-memory front-end: sizes, aligns and extends loads/stores and emulates a
// slow memory by stalling the pipeline LATENCY cycles before committing.
module dmem_ctrl #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_hold_load;

    logic [1:0]  w_off;
    logic        w_misalign;
    logic        w_accept;
    logic        w_complete;
    logic        w_load_done;
    logic        w_held;
    logic [31:0] w_load_fmt;

    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   fmt_load = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: fmt_load = word;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] size);
        case (size)
            2'b00:   lane_data = {4{wd[7:0]}};
            2'b01:   lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    assign w_off      = req_addr_i[1:0];
    // Size 11 decodes as word via size[1].
    assign w_misalign = req_valid_i &&
                        (((req_size_i == 2'b01) && w_off[0]) || (req_size_i[1] && (w_off != 2'b00)));
    assign w_accept   = !rst_i && (r_state == IDLE) && req_valid_i && !w_misalign;
    assign w_complete = !rst_i && ((w_accept && ZERO_LAT) || ((r_state == WAIT) && (r_cnt == '0)));
    assign w_load_done = w_complete && !req_we_i;
    assign w_held     = !rst_i && (r_state == DONE) && r_hold_load;
    assign w_load_fmt = fmt_load(mem_rdata_i, w_off, req_size_i, req_unsigned_i);

    assign stall_o       = !rst_i && ((w_accept && !ZERO_LAT) || ((r_state == WAIT) && (r_cnt != '0)));
    assign mem_we_o      = w_complete && req_we_i;
    assign rdata_valid_o = w_load_done || w_held;
    assign rdata_o       = w_load_done ? w_load_fmt : (w_held ? r_rdata : 32'b0);
    assign misalign_o    = !rst_i && (r_state == IDLE) && w_misalign;
    assign mem_addr_o    = req_addr_i[ADDR_W+1:2];
    assign mem_be_o      = lane_be(w_off, req_size_i);
    assign mem_wdata_o   = lane_data(req_wdata_i, req_size_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_load <= 1'b0;
        end else if (w_complete) begin
            // A frozen pipeline cannot consume the result yet, so park it in DONE.
            if (hold_i) begin
                r_state     <= DONE;
                r_hold_load <= !req_we_i;
                r_rdata     <= w_load_fmt;
            end else begin
                r_state     <= IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                WAIT: r_cnt <= r_cnt - 1'b1;
                DONE: begin
                    if (!hold_i) begin
                        r_state     <= IDLE;
                        r_hold_load <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_dmem_ctrl;

    typedef struct {
        logic [1:0]  kind;   // 0 store, 1 load, 2 misalign
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mclr = 1'b1;
    always #5 clk = ~clk;

    logic        s2_valid = 0, s2_we = 0, s2_uns = 0, s2_hold = 0;
    logic [31:0] s2_addr = 0, s2_wd = 0;
    logic [1:0]  s2_size = 0;
    logic        s2_stall, s2_rv, s2_mis, s2_mwe;
    logic [31:0] s2_rd, s2_mwd, s2_mrd;
    logic [9:0]  s2_maddr;
    logic [3:0]  s2_be;

    logic        s0_valid = 0, s0_we = 0, s0_uns = 0, s0_hold = 0;
    logic [31:0] s0_addr = 0, s0_wd = 0;
    logic [1:0]  s0_size = 0;
    logic        s0_stall, s0_rv, s0_mis, s0_mwe;
    logic [31:0] s0_rd, s0_mwd, s0_mrd;
    logic [9:0]  s0_maddr;
    logic [3:0]  s0_be;

    logic [31:0] mem2 [0:1023];
    logic [31:0] mem0 [0:1023];

    dmem_ctrl #(.LATENCY(2), .ADDR_W(10)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(s2_valid), .req_we_i(s2_we),
        .req_addr_i(s2_addr), .req_wdata_i(s2_wd), .req_size_i(s2_size),
        .req_unsigned_i(s2_uns), .hold_i(s2_hold), .stall_o(s2_stall),
        .rdata_o(s2_rd), .rdata_valid_o(s2_rv), .misalign_o(s2_mis),
        .mem_addr_o(s2_maddr), .mem_we_o(s2_mwe), .mem_be_o(s2_be),
        .mem_wdata_o(s2_mwd), .mem_rdata_i(s2_mrd));

    dmem_ctrl #(.LATENCY(0), .ADDR_W(10)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(s0_valid), .req_we_i(s0_we),
        .req_addr_i(s0_addr), .req_wdata_i(s0_wd), .req_size_i(s0_size),
        .req_unsigned_i(s0_uns), .hold_i(s0_hold), .stall_o(s0_stall),
        .rdata_o(s0_rd), .rdata_valid_o(s0_rv), .misalign_o(s0_mis),
        .mem_addr_o(s0_maddr), .mem_we_o(s0_mwe), .mem_be_o(s0_be),
        .mem_wdata_o(s0_mwd), .mem_rdata_i(s0_mrd));

    assign s2_mrd = mem2[s2_maddr];
    assign s0_mrd = mem0[s0_maddr];

    always @(posedge clk) begin
        if (mclr) begin
            for (int i = 0; i < 1024; i++) mem2[i] <= 32'b0;
        end else if (s2_mwe) begin
            for (int k = 0; k < 4; k++)
                if (s2_be[k]) mem2[s2_maddr][8*k +: 8] <= s2_mwd[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        if (mclr) begin
            for (int i = 0; i < 1024; i++) mem0[i] <= 32'b0;
        end else if (s0_mwe) begin
            for (int k = 0; k < 4; k++)
                if (s0_be[k]) mem0[s0_maddr][8*k +: 8] <= s0_mwd[8*k +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_evt(input string nm, input exp_t e, input logic we, input logic rv,
                           input logic [9:0] ma, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd);
        logic [1:0] k;
        k = we ? 2'd0 : (rv ? 2'd1 : 2'd2);
        chk({nm, "_kind"}, {30'b0, k}, {30'b0, e.kind});
        if (e.kind == 2'd0 && k == 2'd0) begin
            chk({nm, "_addr"}, {22'b0, ma}, {22'b0, e.addr});
            chk({nm, "_be"}, {28'b0, be}, {28'b0, e.be});
            chk({nm, "_wdata"}, wd, e.data);
        end else if (e.kind == 2'd1 && k == 2'd1) begin
            chk({nm, "_rdata"}, rd, e.data);
        end
    endtask

    // Monitors: every output event must match the oldest expectation.
    always @(negedge clk) begin
        if (s2_mwe || s2_rv || s2_mis) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL dut2_unexpected: we=%b rv=%b mis=%b expected no event", s2_mwe, s2_rv, s2_mis);
            end else begin
                cmp_evt("dut2", q2.pop_front(), s2_mwe, s2_rv, s2_maddr, s2_be, s2_mwd, s2_rd);
            end
        end
    end

    always @(negedge clk) begin
        if (s0_mwe || s0_rv || s0_mis) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0_unexpected: we=%b rv=%b mis=%b expected no event", s0_mwe, s0_rv, s0_mis);
            end else begin
                cmp_evt("dut0", q0.pop_front(), s0_mwe, s0_rv, s0_maddr, s0_be, s0_mwd, s0_rd);
            end
        end
    end

    task automatic push2(input logic [1:0] kind, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.addr = a; e.be = be; e.data = d;
        q2.push_back(e);
    endtask

    task automatic push0(input logic [1:0] kind, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.addr = a; e.be = be; e.data = d;
        q0.push_back(e);
    endtask

    // One request on the LATENCY=2 instance; hold_cyc>0 keeps hold_i high from
    // the completion cycle for hold_cyc cycles, then releases it inside DONE.
    task automatic req2(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input logic uns, input int hold_cyc);
        int n;
        s2_valid = 1; s2_we = we; s2_addr = addr; s2_wd = wd; s2_size = size; s2_uns = uns;
        s2_hold = (hold_cyc > 0);
        n = 0;
        @(negedge clk);
        while (s2_stall && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("stall_len", n, 32'd2);
        if (hold_cyc > 0) begin
            for (int k = 1; k < hold_cyc; k++) begin
                @(posedge clk); #1;
                chk("done_no_stall", {31'b0, s2_stall}, 32'd0);
            end
            @(posedge clk); #1;
            s2_hold = 0;
        end
        @(posedge clk); #1;
        s2_valid = 0; s2_hold = 0;
        @(negedge clk);
        chk("idle_rv", {31'b0, s2_rv}, 32'd0);
        chk("idle_stall", {31'b0, s2_stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic mis2(input logic we, input logic [31:0] addr, input logic [1:0] size);
        push2(2'd2, 10'd0, 4'd0, 32'd0);
        s2_valid = 1; s2_we = we; s2_addr = addr; s2_wd = 32'h0BADF00D; s2_size = size; s2_uns = 0;
        @(negedge clk);
        chk("mis_stall", {31'b0, s2_stall}, 32'd0);
        chk("mis_we", {31'b0, s2_mwe}, 32'd0);
        @(posedge clk); #1;
        s2_valid = 0;
        @(negedge clk);
        chk("mis_after_stall", {31'b0, s2_stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with an aligned store presented: nothing may happen.
        s2_valid = 1; s2_we = 1; s2_addr = 32'h8; s2_wd = 32'h55555555; s2_size = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, s2_stall}, 32'd0);
        chk("rst_we", {31'b0, s2_mwe}, 32'd0);
        chk("rst_rv", {31'b0, s2_rv}, 32'd0);
        chk("rst_rdata", s2_rd, 32'd0);
        chk("rst_mis", {31'b0, s2_mis}, 32'd0);
        @(posedge clk); #1;
        s2_valid = 0; rst = 0; mclr = 0;
        @(posedge clk); #1;

        push2(2'd0, 10'd2, 4'hF, 32'hDEADBEEF);
        req2(1, 32'h08, 32'hDEADBEEF, 2'b10, 0, 0);
        chk("mem_w2", mem2[2], 32'hDEADBEEF);
        push2(2'd0, 10'd1, 4'hF, 32'h123480F0);
        req2(1, 32'h04, 32'h123480F0, 2'b10, 0, 0);

        push2(2'd1, 0, 0, 32'hFFFFFF80); req2(0, 32'h05, 0, 2'b00, 0, 0);
        push2(2'd1, 0, 0, 32'h00000080); req2(0, 32'h05, 0, 2'b00, 1, 0);
        push2(2'd1, 0, 0, 32'h00001234); req2(0, 32'h06, 0, 2'b01, 0, 0);

        push2(2'd0, 10'd3, 4'b1100, 32'hABCDABCD);
        req2(1, 32'h0E, 32'h5555ABCD, 2'b01, 0, 0);
        push2(2'd1, 0, 0, 32'hABCD0000); req2(0, 32'h0C, 0, 2'b10, 0, 0);
        push2(2'd1, 0, 0, 32'hFFFFABCD); req2(0, 32'h0E, 0, 2'b01, 0, 0);
        push2(2'd1, 0, 0, 32'h0000ABCD); req2(0, 32'h0E, 0, 2'b01, 1, 0);
        push2(2'd1, 0, 0, 32'h00000000); req2(0, 32'h0C, 0, 2'b01, 0, 0);

        push2(2'd0, 10'd2, 4'b0010, 32'h77777777);
        req2(1, 32'h09, 32'h12345677, 2'b00, 0, 0);
        push2(2'd1, 0, 0, 32'hDEAD77EF); req2(0, 32'h08, 0, 2'b10, 0, 0);
        push2(2'd1, 0, 0, 32'hDEAD77EF); req2(0, 32'h1008, 0, 2'b10, 0, 0);
        push2(2'd1, 0, 0, 32'h123480F0); req2(0, 32'h04, 0, 2'b11, 0, 0);

        mis2(0, 32'h06, 2'b10);
        mis2(0, 32'h05, 2'b01);
        mis2(1, 32'h0A, 2'b10);
        chk("mis_mem", mem2[2], 32'hDEAD77EF);

        // Held load: completion plus one held cycle plus the release cycle.
        repeat (3) push2(2'd1, 0, 0, 32'h123480F0);
        req2(0, 32'h04, 0, 2'b10, 0, 2);
        push2(2'd0, 10'd12, 4'hF, 32'hCAFEF00D);
        req2(1, 32'h30, 32'hCAFEF00D, 2'b10, 0, 2);
        chk("hold_store_mem", mem2[12], 32'hCAFEF00D);

        // Reset lands on the cnt=0 cycle of a store.
        s2_valid = 1; s2_we = 1; s2_addr = 32'h08; s2_wd = 32'h11111111; s2_size = 2'b10;
        @(negedge clk);
        chk("abort_stall0", {31'b0, s2_stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("abort_we", {31'b0, s2_mwe}, 32'd0);
        chk("abort_stall_rst", {31'b0, s2_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 0; s2_valid = 0;
        @(negedge clk);
        chk("abort_stall_after", {31'b0, s2_stall}, 32'd0);
        chk("abort_mem", mem2[2], 32'hDEAD77EF);
        @(posedge clk); #1;

        // Zero-latency instance: back-to-back sw/lw every cycle.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            v = 32'h0BAD0000 | (32'h00110011 * (i + 1));
            push0(2'd0, 10'd4, 4'hF, v);
            s0_valid = 1; s0_we = 1; s0_addr = 32'h10; s0_wd = v; s0_size = 2'b10;
            @(negedge clk);
            chk("lat0_stall_sw", {31'b0, s0_stall}, 32'd0);
            @(posedge clk); #1;
            push0(2'd1, 0, 0, v);
            s0_we = 0; s0_wd = 32'h0;
            @(negedge clk);
            chk("lat0_stall_lw", {31'b0, s0_stall}, 32'd0);
            @(posedge clk); #1;
        end
        s0_valid = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("q2_drain", q2.size(), 32'd0);
        chk("q0_drain", q0.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
